bcd_word_builder: RTL and testbench
===================================

Name: bcd_word_builder

Overview:
- Sequential binary-to-packed-BCD converter that produces the 24-bit, six-nibble operand words consumed by the six-digit seven-segment display path.
- Converts a binary result, either unsigned or two's-complement signed, using shift-and-add-3 (double dabble), one bit per clock.
- Optionally inserts a sign nibble at digit 1 ([23:20]).
- Sits between the arithmetic/result registers and the display controller's op inputs.

Parameters:
- WIDTH, 20, bit width of the binary input. Legal range 4..24.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a conversion; sampled only in IDLE.
- value  input  WIDTH  binary operand, captured when start is accepted.
- signed_mode  input  1  1: value is two's complement, output is a sign nibble plus 5 digits. 0: value is unsigned, output is 6 digits.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when bcd_word is updated.
- overflow  output  1  registered with done; magnitude exceeded the displayable range.
- bcd_word  output  24  packed result; nibble [23:20] is digit 1 (leftmost), [3:0] is digit 6.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, busy=0, done=0, overflow=0, bcd_word=24'h000000, bit counter=0, internal shift registers=0.
- States:
  - IDLE: start=1 captures the magnitude and signed_mode, loads a 28-bit BCD accumulator with 0, sets counter=WIDTH, then goes to CONV with busy=1.
  - CONV: each cycle, every accumulator nibble >=5 gets +3, then {acc,mag} shifts left by 1 and counter decrements. On the cycle counter reaches 1, the final shift result is formatted into bcd_word, done=1, busy=0, and the state returns to IDLE.
- Latency: start accepted at edge k; done is high for exactly the one cycle following edge k+WIDTH. bcd_word is stable from that edge until the next done.
- start while busy=1: ignored, no queueing. start in the same cycle done is high: accepted, because the FSM is already IDLE.
- Magnitude:
  - signed_mode=0: magnitude = value.
  - signed_mode=1: magnitude = value[WIDTH-1] ? -value : value, computed at WIDTH+1 bits so that the most-negative input is exact.
- Formatting, unsigned: accumulator >999999 gives bcd_word=24'h999999 and overflow=1. Otherwise bcd_word = acc[23:0] and overflow=0.
- Formatting, signed: [23:20] = SIGN_NEG if the input was negative and non-zero, else SIGN_POS. Magnitude >99999 saturates [19:0] to 20'h99999 and sets overflow=1.
- -0 cannot occur; zero is always SIGN_POS.
- overflow holds its value until the next done.
- Reset mid-CONV: immediate abort to reset values; no done is issued.
- value changing during CONV has no effect, because it was captured at start.

Optional Feature:
- Macro: BCD_LEADING_BLANK_EN.
- Defined: leading zero digits are replaced by BLANK_NIBBLE (4'hF). The least significant digit is never blanked, and the sign nibble is never blanked.
  - Example: 42 unsigned gives 24'hFFFF42.
- Undefined: leading zeros are kept as 4'h0.
- Blanking is applied in the done cycle only. Latency is unchanged.

Decomposition:
- Package bcd_pkg holds:
  - SIGN_POS=4'h0 and SIGN_NEG=4'h1, the codes the display sign decoder interprets.
  - BLANK_NIBBLE=4'hF.
  - MAX_UNSIGNED_BCD=24'h999999 and MAX_SIGNED_BCD=20'h99999.
  - An FSM state typedef {IDLE, CONV}.
- One natural sub-module: bcd_add3, a combinational 4-bit corrector (in>=5 ? in+3 : in), instantiated 7 times across the accumulator.

Test Plan:
1. Unsigned: value=123456, signed_mode=0, start pulse -> done exactly 20 cycles after the start edge, bcd_word=24'h123456, overflow=0; busy high for 20 cycles.
2. Signed negative: value=20'hFFFD6 (-42), signed_mode=1 -> bcd_word=24'h100042, overflow=0.
   - With BCD_LEADING_BLANK_EN: 24'h1FFF42.
3. Saturation:
   - value=1000000, signed_mode=0 -> bcd_word=24'h999999, overflow=1.
   - value=20'h80000 (-524288), signed_mode=1 -> 24'h199999, overflow=1.
4. Busy and back-to-back:
   - start asserted again 5 cycles into a conversion is ignored; exactly one done, result from the first value.
   - start held high through the done cycle -> second conversion begins immediately, and its done arrives 20 cycles later.
5. Reset mid-conversion: rst_n low at cycle 10 of CONV -> busy=0, bcd_word=24'h000000, no done. After release, value=0 -> 24'h000000 (blank-enabled: 24'hFFFFF0).
6. Zero and sign: value=0, signed_mode=1 -> 24'h000000 with SIGN_POS. value=99999, signed_mode=1 -> 24'h099999, overflow=0.

Source files
------------

// File: rtl/bcd_word_builder_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared constants and types for the binary-to-packed-BCD word builder.
//   SIGN_POS / SIGN_NEG : sign-nibble codes understood by the display sign decoder
//   BLANK_NIBBLE        : nibble code the display renders as an unlit digit
//   MAX_UNSIGNED_BCD    : saturation value for six unsigned digits
//   MAX_SIGNED_BCD      : saturation value for the five magnitude digits
//   bcd_state_e         : converter FSM states
//   blank_leading()     : replaces leading zero digits with BLANK_NIBBLE
// -----------------------------------------------------------------------------
package bcd_pkg;

   localparam logic [3:0]  SIGN_POS         = 4'h0;
   localparam logic [3:0]  SIGN_NEG         = 4'h1;
   localparam logic [3:0]  BLANK_NIBBLE     = 4'hF;
   localparam logic [23:0] MAX_UNSIGNED_BCD = 24'h999999;
   localparam logic [19:0] MAX_SIGNED_BCD   = 20'h99999;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      CONV = 1'b1
   } bcd_state_e;

   // Walks from the leftmost digit towards the right, blanking zeros until
   // the first non-zero digit. Digit 6 ([3:0]) is never blanked so that a
   // zero result still shows "0". When skip_sign is set, [23:20] holds the
   // sign code and is left untouched.
   function automatic logic [23:0] blank_leading(input logic [23:0] word,
                                                 input logic        skip_sign);
      logic [23:0] res;
      logic        lead;
      res  = word;
      lead = 1'b1;
      for (int d = 5; d >= 1; d--) begin
         if ((d == 5) && skip_sign) begin
            lead = lead;
         end else if (lead && (word[4*d +: 4] == 4'h0)) begin
            res[4*d +: 4] = BLANK_NIBBLE;
         end else begin
            lead = 1'b0;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/bcd_word_builder_if.sv
// -----------------------------------------------------------------------------
// bcd_word_builder_if
// Request/result bundle between the result registers and the BCD converter.
//   start       : request a conversion (master -> slave)
//   value       : binary operand, WIDTH bits (master -> slave)
//   signed_mode : 1 = two's complement operand with sign nibble (master -> slave)
//   busy        : conversion in progress (slave -> master)
//   done        : one-cycle pulse when bcd_word updates (slave -> master)
//   overflow    : magnitude saturated, valid with done (slave -> master)
//   bcd_word    : packed six-nibble result (slave -> master)
// -----------------------------------------------------------------------------
interface bcd_word_builder_if #(
   parameter int WIDTH = 20
);
   logic             start;
   logic [WIDTH-1:0] value;
   logic             signed_mode;
   logic             busy;
   logic             done;
   logic             overflow;
   logic [23:0]      bcd_word;

   modport master (
      output start, value, signed_mode,
      input  busy, done, overflow, bcd_word
   );

   modport slave (
      input  start, value, signed_mode,
      output busy, done, overflow, bcd_word
   );
endinterface

// File: rtl/bcd_word_builder_add3.sv
// -----------------------------------------------------------------------------
// bcd_add3
// Double-dabble digit corrector: adds 3 to a BCD nibble holding 5..9 so that
// the following left shift carries correctly into the next decimal digit.
//   din  : nibble before correction
//   dout : corrected nibble
// -----------------------------------------------------------------------------
module bcd_add3 (
   input  logic [3:0] din,
   output logic [3:0] dout
);

   // Conditional +3 correction
   always_comb begin
      dout = din;
      if (din >= 4'd5) begin
         dout = din + 4'd3;
      end else begin
         dout = din;
      end
   end

endmodule

// File: rtl/bcd_word_builder.sv
// -----------------------------------------------------------------------------
// bcd_word_builder
// Sequential binary-to-packed-BCD converter (shift-and-add-3, one bit per
// clock) producing the 24-bit operand word for the six-digit display path.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : bcd_word_builder_if.slave (start/value/signed_mode in,
//           busy/done/overflow/bcd_word out)
// A conversion accepted at edge k updates bcd_word at edge k+WIDTH, with done
// high for the following cycle. Signed mode places a sign code in [23:20] and
// five magnitude digits below it; out-of-range magnitudes saturate to all 9s.
// Optional feature macro: BCD_LEADING_BLANK_EN -- when defined, leading zero
// digits of the result are replaced by BLANK_NIBBLE (sign nibble and last
// digit excepted).
// -----------------------------------------------------------------------------
module bcd_word_builder
   import bcd_pkg::*;
#(
   parameter int WIDTH = 20
) (
   input  logic                clk,
   input  logic                rst_n,
   bcd_word_builder_if.slave   bus
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   bcd_state_e        state_r;
   bcd_state_e        state_s;
   logic              load_s;
   logic              finish_s;

   logic [27:0]       acc_r;
   logic [WIDTH-1:0]  mag_r;
   logic [CNT_W-1:0]  cnt_r;
   logic              neg_r;
   logic              sgn_mode_r;
   logic              sticky_r;

   logic              busy_r;
   logic              done_r;
   logic              overflow_r;
   logic [23:0]       bcd_word_r;

   logic [WIDTH-1:0]  mag_s;
   logic              neg_s;
   logic [27:0]       corr_s;
   logic [27:0]       shift_acc_s;
   logic [WIDTH-1:0]  shift_mag_s;
   logic              sticky_s;
   logic [23:0]       fmt_word_s;
   logic              fmt_ovf_s;

   // Seven digit correctors cover the whole 28-bit accumulator
   for (genvar g = 0; g < 7; g++) begin : g_add3
      bcd_add3 u_add3 (
         .din  (acc_r[4*g +: 4]),
         .dout (corr_s[4*g +: 4])
      );
   end

   // Operand magnitude. Negation in WIDTH bits read as unsigned is exact even
   // for the most-negative input (2^(WIDTH-1) fits in WIDTH unsigned bits).
   always_comb begin
      neg_s = bus.signed_mode & bus.value[WIDTH-1];
      mag_s = bus.value;
      if (neg_s) begin
         mag_s = (~bus.value) + {{(WIDTH-1){1'b0}}, 1'b1};
      end else begin
         mag_s = bus.value;
      end
   end

   // One double-dabble step. A bit leaving the top of the accumulator (only
   // possible for wide operands) is remembered so the result saturates.
   always_comb begin
      shift_acc_s = {corr_s[26:0], mag_r[WIDTH-1]};
      shift_mag_s = {mag_r[WIDTH-2:0], 1'b0};
      sticky_s    = sticky_r | corr_s[27];
   end

   // Result formatting applied to the final shift
   always_comb begin
      fmt_word_s = 24'h000000;
      fmt_ovf_s  = 1'b0;
      if (!sgn_mode_r) begin
         fmt_ovf_s = sticky_s | (shift_acc_s[27:24] != 4'h0);
         if (fmt_ovf_s) begin
            fmt_word_s = MAX_UNSIGNED_BCD;
         end else begin
            fmt_word_s = shift_acc_s[23:0];
         end
      end else begin
         fmt_ovf_s = sticky_s | (shift_acc_s[27:20] != 8'h00);
         if (fmt_ovf_s) begin
            fmt_word_s = {(neg_r ? SIGN_NEG : SIGN_POS), MAX_SIGNED_BCD};
         end else begin
            fmt_word_s = {(neg_r ? SIGN_NEG : SIGN_POS), shift_acc_s[19:0]};
         end
      end
`ifdef BCD_LEADING_BLANK_EN
      fmt_word_s = blank_leading(fmt_word_s, sgn_mode_r);
`else
      fmt_word_s = fmt_word_s;
`endif
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // FSM next-state and control strobes
   always_comb begin
      state_s  = state_r;
      load_s   = 1'b0;
      finish_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (bus.start) begin
               load_s  = 1'b1;
               state_s = CONV;
            end else begin
               state_s = IDLE;
            end
         end
         CONV: begin
            if (cnt_r == CNT_W'(1)) begin
               finish_s = 1'b1;
               state_s  = IDLE;
            end else begin
               state_s  = CONV;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Datapath and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_r      <= 28'h0000000;
         mag_r      <= '0;
         cnt_r      <= '0;
         neg_r      <= 1'b0;
         sgn_mode_r <= 1'b0;
         sticky_r   <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         overflow_r <= 1'b0;
         bcd_word_r <= 24'h000000;
      end else begin
         done_r <= 1'b0;
         if (load_s) begin
            acc_r      <= 28'h0000000;
            mag_r      <= mag_s;
            cnt_r      <= CNT_W'(WIDTH);
            neg_r      <= neg_s;
            sgn_mode_r <= bus.signed_mode;
            sticky_r   <= 1'b0;
            busy_r     <= 1'b1;
         end else if (state_r == CONV) begin
            acc_r    <= shift_acc_s;
            mag_r    <= shift_mag_s;
            cnt_r    <= cnt_r - CNT_W'(1);
            sticky_r <= sticky_s;
            if (finish_s) begin
               bcd_word_r <= fmt_word_s;
               overflow_r <= fmt_ovf_s;
               done_r     <= 1'b1;
               busy_r     <= 1'b0;
            end
         end
      end
   end

   assign bus.busy     = busy_r;
   assign bus.done     = done_r;
   assign bus.overflow = overflow_r;
   assign bus.bcd_word = bcd_word_r;

endmodule

// File: tb/tb_bcd_word_builder.sv
// -----------------------------------------------------------------------------
// tb_bcd_word_builder
// Self-checking bench for bcd_word_builder: directed cases plus randomized
// operands compared against a decimal-arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_bcd_word_builder;

   localparam int W = 20;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   bcd_word_builder_if #(.WIDTH(W)) bus ();

   bcd_word_builder #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference: decimal digits from integer arithmetic
   function automatic void model(input logic [W-1:0] v, input logic sm,
                                 output logic [23:0] w, output logic ovf);
      int unsigned mag;
      int unsigned lim;
      int unsigned t;
      int          ndig;
      int          sig;
      logic        neg;
      neg = sm && v[W-1];
      mag = neg ? ((32'd1 << W) - 32'(v)) : 32'(v);
      lim = sm ? 32'd99999 : 32'd999999;
      ndig = sm ? 5 : 6;
      ovf = (mag > lim);
      if (ovf) mag = lim;
      w = 24'h0;
      t = mag;
      for (int i = 0; i < ndig; i++) begin
         w[4*i +: 4] = 4'(t % 10);
         t = t / 10;
      end
      if (sm) w[23:20] = neg ? 4'h1 : 4'h0;
`ifdef BCD_LEADING_BLANK_EN
      sig = 1;
      t = mag;
      while (t >= 10) begin
         t = t / 10;
         sig++;
      end
      for (int i = sig; i < ndig; i++) w[4*i +: 4] = 4'hF;
`else
      sig = 0;
`endif
   endfunction

   task automatic convert(input logic [W-1:0] v, input logic sm,
                          input logic [23:0] exp_w, input logic exp_o, input string tag);
      int n;
      int busy_n;
      bit seen;
      logic [23:0] word;
      @(negedge clk);
      bus.start = 1'b1;
      bus.value = v;
      bus.signed_mode = sm;
      n = 0;
      busy_n = 0;
      seen = 1'b0;
      while (!seen && n < 3*W) begin
         @(negedge clk);
         n++;
         if (n == 1) begin
            bus.start = 1'b0;
            bus.value = W'($urandom);
            bus.signed_mode = 1'($urandom);
         end
         if (bus.busy) busy_n++;
         if (bus.done) seen = 1'b1;
      end
      check_eq({tag, "_done_seen"}, 32'(seen), 32'd1);
      check_eq({tag, "_latency"}, n, W + 1);
      check_eq({tag, "_busy_cycles"}, busy_n, W);
      check_eq({tag, "_word"}, 32'(bus.bcd_word), 32'(exp_w));
      check_eq({tag, "_ovf"}, 32'(bus.overflow), 32'(exp_o));
      word = bus.bcd_word;
      @(negedge clk);
      check_eq({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
      check_eq({tag, "_word_hold"}, 32'(bus.bcd_word), 32'(word));
   endtask

   initial begin
      logic [23:0] ew;
      logic        eo;
      logic [W-1:0] rv;
      logic        rs;
      int          dcnt;
      int          d1;
      int          d2;
      logic [23:0] w1;
      logic [23:0] w2;

      checks = 0;
      failures = 0;
      rst_n = 1'b0;
      bus.start = 1'b0;
      bus.value = '0;
      bus.signed_mode = 1'b0;
      #1;
      check_eq("rst_busy", 32'(bus.busy), 32'd0);
      check_eq("rst_done", 32'(bus.done), 32'd0);
      check_eq("rst_ovf", 32'(bus.overflow), 32'd0);
      check_eq("rst_word", 32'(bus.bcd_word), 32'h0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Directed cases
      convert(20'd123456, 1'b0, 24'h123456, 1'b0, "u123456");
`ifdef BCD_LEADING_BLANK_EN
      convert(20'hFFFD6, 1'b1, 24'h1FFF42, 1'b0, "s_m42");
      convert(20'd0, 1'b1, 24'h0FFFF0, 1'b0, "s_zero");
`else
      convert(20'hFFFD6, 1'b1, 24'h100042, 1'b0, "s_m42");
      convert(20'd0, 1'b1, 24'h000000, 1'b0, "s_zero");
`endif
      convert(20'd1000000, 1'b0, 24'h999999, 1'b1, "u_sat");
      convert(20'h80000, 1'b1, 24'h199999, 1'b1, "s_minneg");
      convert(20'd99999, 1'b1, 24'h099999, 1'b0, "s_99999");

      // Start while busy is ignored
      @(negedge clk);
      bus.start = 1'b1;
      bus.value = 20'd111111;
      bus.signed_mode = 1'b0;
      dcnt = 0;
      d1 = 0;
      w1 = 24'h0;
      for (int n = 1; n <= 3*W; n++) begin
         @(negedge clk);
         if (n == 1) bus.start = 1'b0;
         if (n == 5) begin
            bus.start = 1'b1;
            bus.value = 20'd222222;
         end
         if (n == 6) bus.start = 1'b0;
         if (bus.done) begin
            dcnt++;
            if (dcnt == 1) begin
               d1 = n;
               w1 = bus.bcd_word;
            end
         end
      end
      model(20'd111111, 1'b0, ew, eo);
      check_eq("ign_done_count", dcnt, 1);
      check_eq("ign_latency", d1, W + 1);
      check_eq("ign_word", 32'(w1), 32'(ew));

      // Start held through the done cycle: back-to-back conversions
      @(negedge clk);
      bus.start = 1'b1;
      bus.value = 20'd654321;
      bus.signed_mode = 1'b0;
      d1 = 0;
      d2 = 0;
      w1 = 24'h0;
      w2 = 24'h0;
      for (int n = 1; n <= 3*W && d2 == 0; n++) begin
         @(negedge clk);
         if (n == 1) begin
            bus.value = 20'hFF000;
            bus.signed_mode = 1'b1;
         end
         if (d1 != 0 && n == d1 + 1) bus.start = 1'b0;
         if (bus.done) begin
            if (d1 == 0) begin
               d1 = n;
               w1 = bus.bcd_word;
            end else begin
               d2 = n;
               w2 = bus.bcd_word;
            end
         end
      end
      bus.start = 1'b0;
      check_eq("b2b_first_lat", d1, W + 1);
      check_eq("b2b_second_lat", d2 - d1, W + 1);
      model(20'd654321, 1'b0, ew, eo);
      check_eq("b2b_first_word", 32'(w1), 32'(ew));
      model(20'hFF000, 1'b1, ew, eo);
      check_eq("b2b_second_word", 32'(w2), 32'(ew));
      repeat (2) @(negedge clk);

      // Reset mid-conversion
      @(negedge clk);
      bus.start = 1'b1;
      bus.value = 20'd123456;
      bus.signed_mode = 1'b0;
      for (int n = 1; n <= 10; n++) begin
         @(negedge clk);
         if (n == 1) bus.start = 1'b0;
      end
      check_eq("mid_busy_before", 32'(bus.busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check_eq("mid_busy", 32'(bus.busy), 32'd0);
      check_eq("mid_word", 32'(bus.bcd_word), 32'h0);
      check_eq("mid_done", 32'(bus.done), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      dcnt = 0;
      for (int n = 0; n < 2*W; n++) begin
         @(negedge clk);
         if (bus.done) dcnt++;
      end
      check_eq("mid_no_done", dcnt, 0);
`ifdef BCD_LEADING_BLANK_EN
      convert(20'd0, 1'b0, 24'hFFFFF0, 1'b0, "u_zero");
`else
      convert(20'd0, 1'b0, 24'h000000, 1'b0, "u_zero");
`endif

      // Randomized operands against the reference model
      for (int i = 0; i < 30; i++) begin
         case ($urandom_range(0, 3))
            0: rv = W'($urandom_range(0, 200));
            1: rv = W'($urandom_range(99990, 100010));
            2: rv = W'($urandom_range(999990, 1048575));
            default: rv = W'($urandom);
         endcase
         rs = 1'($urandom_range(0, 1));
         model(rv, rs, ew, eo);
         convert(rv, rs, ew, eo, "rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
